// File: rtl/seg7_pkg.sv
// Shared encodings for the seg7 scan controller: FSM states and the
// active-low hex segment table (bit0=a .. bit6=g).
package seg7_pkg;

    localparam logic [1:0] S_OFF    = 2'd0;
    localparam logic [1:0] S_COMMIT = 2'd1;
    localparam logic [1:0] S_DRIVE  = 2'd2;
    localparam logic [1:0] S_BLANK  = 2'd3;

    typedef enum logic [1:0] {
        ST_OFF    = S_OFF,
        ST_COMMIT = S_COMMIT,
        ST_DRIVE  = S_DRIVE,
        ST_BLANK  = S_BLANK
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry 15 first, entry 0 last.
    localparam logic [15:0][6:0] SEG_TAB = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Digit write port of the seg7 scan controller (valid/ready).
interface seg7_scan_ctrl_if #(
    parameter int IDX_W = 2
);
    logic             wr_valid;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_addr;
    logic [3:0]       wr_data;

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb seg = SEG_TAB[nib];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed hex display scanner with shadow/active digit banks.
// Optional leading-zero blanking: define SEG7_LEAD_ZERO_BLANK_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int SCAN_DIV     = 50000,
    parameter  int BLANK_CYCLES = 500,
    localparam int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  enable,
    seg7_scan_ctrl_if.slave       wr,
    output logic [6:0]            seg_n,
    output logic [NUM_DIGITS-1:0] dig_en_n,
    output logic [IDX_W-1:0]      scan_idx,
    output logic                  frame_done
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] DRV_LAST =
        CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t                     state, state_d;
    logic [CNT_W-1:0]           cnt, cnt_d;
    logic [IDX_W-1:0]           idx, idx_d;
    logic [NUM_DIGITS-1:0][3:0] shadow, active;
    logic [6:0]                 dec_seg;
    logic                       blank_sel;
    logic                       wr_fire;

    assign wr.wr_ready = (state != ST_COMMIT);
    assign wr_fire     = wr.wr_valid && wr.wr_ready;
    assign frame_done  = (state == ST_COMMIT);
    assign scan_idx    = idx;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= ST_OFF;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        if (!enable) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state)
                ST_OFF: state_d = ST_COMMIT;
                ST_COMMIT: begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                ST_DRIVE: begin
                    if (cnt == DRV_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (cnt == BLK_LAST) begin
                        cnt_d = '0;
                        if (idx == LAST_IDX) begin
                            state_d = ST_COMMIT;
                            idx_d   = '0;
                        end else begin
                            state_d = ST_DRIVE;
                            idx_d   = idx + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Shadow takes writes; active only changes at a frame boundary.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (wr_fire && int'(wr.wr_addr) < NUM_DIGITS)
                shadow[wr.wr_addr] <= wr.wr_data;
            if (state == ST_COMMIT)
                active <= shadow;
        end
    end

`ifdef SEG7_LEAD_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank, blank_d;
    logic                  zrun;

    always_comb begin
        blank_d = '0;
        zrun    = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zrun       = zrun & (shadow[i] == 4'h0);
            blank_d[i] = zrun;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            blank <= '0;
        else if (state == ST_COMMIT)
            blank <= blank_d;
    end

    assign blank_sel = blank[idx];
`else
    assign blank_sel = 1'b0;
`endif

    seg7_hex_decode u_dec (
        .nib (active[idx]),
        .seg (dec_seg)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            seg_n    <= SEG_OFF;
            dig_en_n <= '1;
        end else if (state == ST_DRIVE) begin
            seg_n    <= blank_sel ? SEG_OFF : dec_seg;
            dig_en_n <= ~(NUM_DIGITS'(1) << idx);
        end else begin
            seg_n    <= SEG_OFF;
            dig_en_n <= '1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles),
// compared every cycle against a frame-position reference model.
module tb_seg7_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [6:0] seg_n;
    logic [3:0] dig_en_n;
    logic [1:0] scan_idx;
    logic       frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_scan_ctrl_if #(.IDX_W(2)) wr_if ();

    seg7_scan_ctrl #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (rst_n),
        .enable     (en),
        .wr         (wr_if),
        .seg_n      (seg_n),
        .dig_en_n   (dig_en_n),
        .scan_idx   (scan_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference: ph is the position within a 33-cycle frame, 0 = commit.
    bit         run;
    int         ph;
    logic [3:0] sh  [4];
    logic [3:0] act [4];
    logic [6:0] eseg;
    logic [3:0] edig;
    bit         m_cm;
    int         m_d;

    function automatic bit lz(int d);
`ifdef SEG7_LEAD_ZERO_BLANK_EN
        if (d == 0) return 1'b0;
        for (int j = d; j < 4; j++)
            if (act[j] != 4'h0) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run  = 1'b0;
            ph   = 0;
            eseg = 7'h7F;
            edig = 4'hF;
            for (int i = 0; i < 4; i++) begin
                sh[i]  = 4'h0;
                act[i] = 4'h0;
            end
        end else begin
            if (run && ph >= 1 && (ph - 1) % 8 < 6) begin
                m_d  = (ph - 1) / 8;
                edig = ~(4'b0001 << m_d);
                eseg = lz(m_d) ? 7'h7F : hex_tab[act[m_d]];
            end else begin
                edig = 4'hF;
                eseg = 7'h7F;
            end
            m_cm = run && ph == 0;
            if (wr_if.wr_valid && !m_cm && int'(wr_if.wr_addr) < 4)
                sh[wr_if.wr_addr] = wr_if.wr_data;
            if (m_cm)
                for (int i = 0; i < 4; i++) act[i] = sh[i];
            if (!en) begin
                run = 1'b0;
                ph  = 0;
            end else if (!run) begin
                run = 1'b1;
                ph  = 0;
            end else begin
                ph = (ph + 1) % 33;
            end
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        bit cm;
        int si;
        cm = run && ph == 0;
        si = (run && ph > 0) ? (ph - 1) / 8 : 0;
        chk("seg_n", seg_n, eseg);
        chk("dig_en_n", dig_en_n, edig);
        chk("frame_done", frame_done, cm);
        chk("wr_ready", wr_if.wr_ready, !cm);
        chk("scan_idx", scan_idx, si);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk_all();
    endtask

    task automatic wr(int a, int d);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = 2'(a);
        wr_if.wr_data  = 4'(d);
        tick();
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic wait_ph(int p);
        for (int i = 0; i < 80; i++) begin
            if (run && ph == p) break;
            tick();
        end
    endtask

    int c1;

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_addr  = '0;
        wr_if.wr_data  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-DRIVE goes dark at once
        en = 1'b1;
        wait_ph(5);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_seg", seg_n, 7'h7F);
        chk("t1_dig", dig_en_n, 4'hF);
        chk("t1_rdy", wr_if.wr_ready, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("t1_seg0", seg_n, 7'h40);
        chk("t1_dig0", dig_en_n, 4'hE);

        // Basic frame
        en = 1'b0;
        tick();
        tick();
        wr(0, 1);
        wr(1, 2);
        wr(2, 3);
        wr(3, 4);
        en = 1'b1;
        tick();
        chk("t2_fd", frame_done, 1'b1);
        tick();
        tick();
        chk("t2_seg", seg_n, 7'h79);
        chk("t2_dig", dig_en_n, 4'hE);
        for (int i = 0; i < 40 && !frame_done; i++) tick();
        c1 = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            c1++;
            if (frame_done) break;
        end
        chk("t2_period", c1, 33);

        // Write during digit 2 slot shows only after commit
        wait_ph(17);
        wr(1, 15);
        wait_ph(0);
        wait_ph(10);
        chk("t3_d1", seg_n, 7'h0E);

        // Write stalled by COMMIT
        wait_ph(0);
        chk("t4_stall", wr_if.wr_ready, 1'b0);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = 2'd3;
        wr_if.wr_data  = 4'd6;
        tick();
        chk("t4_rdy", wr_if.wr_ready, 1'b1);
        tick();
        wr_if.wr_valid = 1'b0;
        wait_ph(0);
        wait_ph(26);
        chk("t4_d3", seg_n, 7'h02);

        // Disable mid-DRIVE of digit 2
        wait_ph(19);
        en = 1'b0;
        tick();
        chk("t5_lit", dig_en_n, 4'hB);
        tick();
        chk("t5_dark", dig_en_n, 4'hF);
        tick();
        en = 1'b1;
        tick();
        chk("t5_fd", frame_done, 1'b1);
        tick();
        tick();
        chk("t5_d0", dig_en_n, 4'hE);

        // Leading zeros
        wait_ph(1);
        wr(0, 0);
        wr(1, 5);
        wr(2, 0);
        wr(3, 0);
        wait_ph(0);
        wait_ph(2);
        chk("t6_d0", seg_n, 7'h40);
        wait_ph(10);
        chk("t6_d1", seg_n, 7'h12);
        wait_ph(18);
`ifdef SEG7_LEAD_ZERO_BLANK_EN
        chk("t6_d2", seg_n, 7'h7F);
`else
        chk("t6_d2", seg_n, 7'h40);
`endif
        wait_ph(26);
`ifdef SEG7_LEAD_ZERO_BLANK_EN
        chk("t6_d3", seg_n, 7'h7F);
`else
        chk("t6_d3", seg_n, 7'h40);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 63) != 0);
            wr_if.wr_valid = 1'($urandom_range(0, 1));
            wr_if.wr_addr  = 2'($urandom_range(0, 3));
            wr_if.wr_data  = ($urandom_range(0, 2) == 0) ?
                             4'h0 : 4'($urandom_range(0, 15));
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rnd_rst_seg", seg_n, 7'h7F);
                chk("rnd_rst_dig", dig_en_n, 4'hF);
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
